// File: rtl/pipe_pkg.sv
// Shared pipeline types for the operand forwarding and hazard logic.
// Forward selects, stall FSM states and the hard-wired zero register.
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    ST_IDLE,
    ST_STALL
  } stall_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_compare.sv
// Per-source producer compare in D.
// The youngest producer (E) wins over M; x0 never matches.
module fwd_compare
  import pipe_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rd_e,
  input  logic [AW-1:0] rd_m,
  input  logic          reg_write_e,
  input  logic          reg_write_m,
  output logic          match_e,
  output logic          match_m,
  output fwd_sel_t      sel
);

  logic nz;

  assign nz      = (rs != AW'(REG_ZERO));
  assign match_e = nz && (rs == rd_e);
  assign match_m = nz && (rs == rd_m);

  always_comb begin
    sel = FWD_RF;
    if (match_e && reg_write_e)
      sel = FWD_M;
    else if (match_m && reg_write_m)
      sel = FWD_W;
  end

endmodule

// File: rtl/mux_3_1.sv
// Generic three-input operand mux.
// Select 2'b11 falls back to d0.
module mux_3_1 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    unique case (s)
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/operand_forward_unit.sv
// E-stage operand resolver: registered forward selects plus
// load-use stall/flush control with a small counter FSM.
module operand_forward_unit
  import pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NSRC     = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NSRC*AW-1:0]   RsD,
  input  logic [NSRC*AW-1:0]   RsE,
  input  logic [AW-1:0]        RdE,
  input  logic [AW-1:0]        RdM,
  input  logic                 RegWriteE,
  input  logic                 RegWriteM,
  input  logic                 LoadE,
  input  logic                 LoadM,
  input  logic                 PCSrcE,
  input  logic [NSRC*XLEN-1:0] RDE,
  input  logic [XLEN-1:0]      ALUResultM,
  input  logic [XLEN-1:0]      ResultW,
  input  logic [XLEN-1:0]      ImmExtE,
  input  logic                 ALUSrcE,
  output logic [NSRC*XLEN-1:0] SrcE,
  output logic [XLEN-1:0]      WriteDataE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE
);

  localparam int CW = $clog2(LOAD_LAT) + 1;

  if (LOAD_LAT < 1 || LOAD_LAT > 2) begin : g_bad_lat
    $error("operand_forward_unit: LOAD_LAT must be 1 or 2");
  end
  if (NSRC < 2) begin : g_bad_nsrc
    $error("operand_forward_unit: NSRC must be at least 2");
  end

  fwd_sel_t        sel_d [NSRC];
  fwd_sel_t        sel_e [NSRC];
  logic [NSRC-1:0] hit_e;
  logic [NSRC-1:0] hit_m;
  logic [XLEN-1:0] fwd   [NSRC];

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    fwd_compare #(.AW(AW)) u_cmp (
      .rs          (RsD[gi*AW +: AW]),
      .rd_e        (RdE),
      .rd_m        (RdM),
      .reg_write_e (RegWriteE),
      .reg_write_m (RegWriteM),
      .match_e     (hit_e[gi]),
      .match_m     (hit_m[gi]),
      .sel         (sel_d[gi])
    );

    mux_3_1 #(.WIDTH(XLEN)) u_mux (
      .d0 (RDE[gi*XLEN +: XLEN]),
      .d1 (ResultW),
      .d2 (ALUResultM),
      .s  (sel_e[gi]),
      .y  (fwd[gi])
    );

    if (gi == 1) begin : g_opb
      assign SrcE[gi*XLEN +: XLEN] = ALUSrcE ? ImmExtE : fwd[gi];
    end else begin : g_opx
      assign SrcE[gi*XLEN +: XLEN] = fwd[gi];
    end
  end

  assign WriteDataE = fwd[1];

  always_ff @(posedge clk) begin
    if (!reset_n || FlushE) begin
      for (int i = 0; i < NSRC; i++) sel_e[i] <= FWD_RF;
    end else if (!StallD) begin
      for (int i = 0; i < NSRC; i++) sel_e[i] <= sel_d[i];
    end
  end

  stall_state_t   st_q, st_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           haz_e, haz_m, stall;

  assign haz_e = LoadE && RegWriteE && (|hit_e);
  assign haz_m = (LOAD_LAT == 2) && LoadM && RegWriteM && (|hit_m);

  // STALL covers only the bubbles after the detecting cycle.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    stall = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        stall = (haz_e || haz_m) && !PCSrcE;
        if (!PCSrcE && haz_e && LOAD_LAT > 1) begin
          st_d  = ST_STALL;
          cnt_d = CW'(LOAD_LAT - 2);
        end
      end
      ST_STALL: begin
        stall = !PCSrcE;
        if (PCSrcE || cnt_q == '0) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        st_d  = ST_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign StallF = stall;
  assign StallD = stall;
  assign FlushE = stall | PCSrcE;
  assign FlushD = PCSrcE;

  logic unused_rse;
  assign unused_rse = ^RsE;

endmodule

// File: tb/tb_operand_forward_unit.sv
// Scoreboard bench for operand_forward_unit at LOAD_LAT 1 and 2.
// A rule-level model feeds an expectation queue drained by a monitor.
module tb_operand_forward_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  RsD, RsE;
  logic [4:0]  RdE, RdM;
  logic        RegWriteE, RegWriteM, LoadE, LoadM, PCSrcE, ALUSrcE;
  logic [63:0] RDE;
  logic [31:0] ALUResultM, ResultW, ImmExtE;

  logic [63:0] src_e   [2];
  logic [31:0] wd_e    [2];
  logic        stall_f [2];
  logic        stall_d [2];
  logic        flush_d [2];
  logic        flush_e [2];

  always #5 clk = ~clk;

  operand_forward_unit #(.LOAD_LAT(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n), .RsD(RsD), .RsE(RsE),
    .RdE(RdE), .RdM(RdM), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .LoadE(LoadE), .LoadM(LoadM), .PCSrcE(PCSrcE), .RDE(RDE),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .ImmExtE(ImmExtE),
    .ALUSrcE(ALUSrcE), .SrcE(src_e[0]), .WriteDataE(wd_e[0]),
    .StallF(stall_f[0]), .StallD(stall_d[0]),
    .FlushD(flush_d[0]), .FlushE(flush_e[0])
  );

  operand_forward_unit #(.LOAD_LAT(2)) u_lat2 (
    .clk(clk), .reset_n(reset_n), .RsD(RsD), .RsE(RsE),
    .RdE(RdE), .RdM(RdM), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
    .LoadE(LoadE), .LoadM(LoadM), .PCSrcE(PCSrcE), .RDE(RDE),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .ImmExtE(ImmExtE),
    .ALUSrcE(ALUSrcE), .SrcE(src_e[1]), .WriteDataE(wd_e[1]),
    .StallF(stall_f[1]), .StallD(stall_d[1]),
    .FlushD(flush_d[1]), .FlushE(flush_e[1])
  );

  typedef struct packed {
    logic [1:0]            stall;
    logic [1:0]            fe;
    logic                  fd;
    logic [1:0][1:0][31:0] src;
    logic [1:0][31:0]      wd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Model state: which source each E operand currently takes
  // (0 RF, 1 W, 2 M) and how many forced bubbles are still owed.
  int msel [2][2];
  int pend [2];

  function automatic logic [4:0] rs(input int i);
    return RsD[i*5 +: 5];
  endfunction

  function automatic bit uses(input logic [4:0] rd);
    bit r = 0;
    for (int i = 0; i < 2; i++)
      if (rs(i) != 0 && rs(i) == rd) r = 1;
    return r;
  endfunction

  function automatic logic [31:0] pick(input int s, input int i);
    if (s == 1) return ResultW;
    if (s == 2) return ALUResultM;
    return RDE[i*32 +: 32];
  endfunction

  task automatic clear_in();
    RsD = '0; RsE = '0; RdE = '0; RdM = '0;
    RegWriteE = 0; RegWriteM = 0; LoadE = 0; LoadM = 0;
    PCSrcE = 0; ALUSrcE = 0;
    RDE = {$urandom, $urandom};
    ALUResultM = $urandom; ResultW = $urandom; ImmExtE = $urandom;
  endtask

  task automatic step();
    exp_t e;
    bit he, hm, st;
    int lat;
    e = '0;
    e.fd = PCSrcE;
    for (int k = 0; k < 2; k++) begin
      lat = k + 1;
      he = LoadE && RegWriteE && uses(RdE);
      hm = (lat == 2) && LoadM && RegWriteM && uses(RdM);
      st = !PCSrcE && (pend[k] > 0 || he || hm);
      e.stall[k] = st;
      e.fe[k] = st || PCSrcE;
      for (int i = 0; i < 2; i++)
        e.src[k][i] = pick(msel[k][i], i);
      e.wd[k] = e.src[k][1];
      if (ALUSrcE) e.src[k][1] = ImmExtE;
      if (!reset_n) begin
        pend[k] = 0;
        for (int i = 0; i < 2; i++) msel[k][i] = 0;
      end else begin
        if (PCSrcE) pend[k] = 0;
        else if (pend[k] > 0) pend[k] = pend[k] - 1;
        else if (he) pend[k] = lat - 1;
        else pend[k] = 0;
        for (int i = 0; i < 2; i++) begin
          if (st || PCSrcE) msel[k][i] = 0;
          else if (rs(i) != 0 && RegWriteE && rs(i) == RdE) msel[k][i] = 2;
          else if (rs(i) != 0 && RegWriteM && rs(i) == RdM) msel[k][i] = 1;
          else msel[k][i] = 0;
        end
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int k,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lat%0d act=%h exp=%h t=%0t", nm, k + 1, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < 2; k++) begin
          chk("StallF", k, 64'(stall_f[k]), 64'(e.stall[k]));
          chk("StallD", k, 64'(stall_d[k]), 64'(e.stall[k]));
          chk("FlushD", k, 64'(flush_d[k]), 64'(e.fd));
          chk("FlushE", k, 64'(flush_e[k]), 64'(e.fe[k]));
          chk("SrcE", k, src_e[k], {e.src[k][1], e.src[k][0]});
          chk("WriteDataE", k, 64'(wd_e[k]), 64'(e.wd[k]));
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0;
      for (int i = 0; i < 2; i++) msel[k][i] = 0;
    end
    clear_in();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;

    // Idle inputs straight out of reset
    clear_in(); step();

    // ALU producer in E, consumer on rs1
    clear_in(); RsD[4:0] = 5; RdE = 5; RegWriteE = 1; step();
    clear_in(); ALUResultM = 32'h1234; step();

    // Same register in E and M: E must win
    clear_in(); RsD[4:0] = 5; RdE = 5; RdM = 5;
    RegWriteE = 1; RegWriteM = 1; step();
    clear_in(); step();

    // Load-use on rs2, bubble then W forward
    clear_in(); RsD[9:5] = 6; RdE = 6; RegWriteE = 1; LoadE = 1; step();
    clear_in(); RsD[9:5] = 6; RdM = 6; RegWriteM = 1; LoadM = 1; step();
    clear_in(); RsD[9:5] = 6; step();
    clear_in(); ResultW = 32'hCAFE0000; step();

    // Load, independent instruction, then consumer
    clear_in(); RsD[4:0] = 1; RdE = 7; RegWriteE = 1; LoadE = 1; step();
    clear_in(); RsD[4:0] = 7; RdM = 7; RegWriteM = 1; LoadM = 1; step();
    clear_in(); RsD[4:0] = 7; step();

    // x0 is never a hazard nor forwarded
    clear_in(); RdE = 0; RegWriteE = 1; LoadE = 1; step();
    clear_in(); step();

    // Redirect coincident with a load-use hazard
    clear_in(); RsD[4:0] = 3; RdE = 3; RegWriteE = 1; LoadE = 1;
    PCSrcE = 1; step();
    clear_in(); step();

    // Reset while the LOAD_LAT=2 instance is mid-stall
    clear_in(); RsD[4:0] = 4; RdE = 4; RegWriteE = 1; LoadE = 1; step();
    clear_in(); reset_n = 0; step();
    clear_in(); reset_n = 1; step();
    clear_in(); step();

    // Random traffic with small register ranges to force overlaps
    for (int n = 0; n < 600; n++) begin
      RsD = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      RsE = 10'($urandom);
      RdE = 5'($urandom_range(0, 3));
      RdM = 5'($urandom_range(0, 3));
      RegWriteE = 1'($urandom_range(0, 1));
      RegWriteM = 1'($urandom_range(0, 1));
      LoadE = ($urandom_range(0, 2) == 0);
      LoadM = ($urandom_range(0, 2) == 0);
      PCSrcE = ($urandom_range(0, 9) == 0);
      ALUSrcE = 1'($urandom_range(0, 1));
      RDE = {$urandom, $urandom};
      ALUResultM = $urandom; ResultW = $urandom; ImmExtE = $urandom;
      reset_n = ($urandom_range(0, 49) != 0);
      step();
    end
    reset_n = 1;

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain act=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
